// File: rtl/dcache_sram_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_sram_ctrl
//
// Controller for one data-cache SRAM way (simple dual-port RAM with a
// 1-cycle read latency). After reset it sweeps the whole array with zeros.
// It then shares the RAM write port between line refills (LINE_WORDS-beat
// bursts, highest priority) and byte-enabled CPU stores. Reads that hit the
// word being written in the same cycle are forwarded, so the requester
// always sees the newest data.
//
// Ports
//   clk, rst_n            single clock, asynchronous active-low reset
//   init_done             high once the zero-fill sweep has finished
//   rf_req / rf_addr      refill request and line base (low bits ignored)
//   rf_gnt                refill owns the write port
//   rf_wvalid/rf_wdata    refill beat, accepted when rf_wready is high
//   rf_wready, rf_done    beat handshake, pulse on the last beat's write
//   st_valid/st_addr/st_data/st_be, st_ready   CPU store handshake
//   rd_req/rd_addr        read request; rd_valid/rd_data one cycle later
//   sram_wr_*             registered SRAM write port
//   sram_rd_addr/sram_rd_data   SRAM read port
// -----------------------------------------------------------------------------
module dcache_sram_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int LINE_WORDS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_done,
  input  logic                  rf_req,
  input  logic [ADDR_WIDTH-1:0] rf_addr,
  output logic                  rf_gnt,
  input  logic                  rf_wvalid,
  input  logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  rf_wready,
  output logic                  rf_done,
  input  logic                  st_valid,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [BE_WIDTH-1:0]   st_be,
  output logic                  st_ready,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  sram_wr_en,
  output logic [ADDR_WIDTH-1:0] sram_wr_addr,
  output logic [DATA_WIDTH-1:0] sram_wr_data,
  output logic [BE_WIDTH-1:0]   sram_wr_byte_en,
  output logic [ADDR_WIDTH-1:0] sram_rd_addr,
  input  logic [DATA_WIDTH-1:0] sram_rd_data
);

  localparam int CNT_W  = ADDR_WIDTH + 1;
  localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_WORDS - 1);
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_REFILL
  } state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        init_cnt_reg, init_cnt_next;
  logic [BEAT_W-1:0]       beat_cnt_reg, beat_cnt_next;
  logic [ADDR_WIDTH-1:0]   base_reg, base_next;
  logic                    init_done_reg, init_done_next;
  logic                    rf_done_reg, rf_done_next;
  logic                    wr_en_reg, wr_en_next;
  logic [ADDR_WIDTH-1:0]   wr_addr_reg, wr_addr_next;
  logic [DATA_WIDTH-1:0]   wr_data_reg, wr_data_next;
  logic [BE_WIDTH-1:0]     wr_be_reg, wr_be_next;

  logic                    rd_valid_reg;
  logic                    fwd_hit_reg;
  logic [DATA_WIDTH-1:0]   fwd_data_reg;
  logic [BE_WIDTH-1:0]     fwd_be_reg;

  // ---------------------------------------------------------------------------
  // State and write-port registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_INIT;
      init_cnt_reg  <= '0;
      beat_cnt_reg  <= '0;
      base_reg      <= '0;
      init_done_reg <= 1'b0;
      rf_done_reg   <= 1'b0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      wr_be_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      init_cnt_reg  <= init_cnt_next;
      beat_cnt_reg  <= beat_cnt_next;
      base_reg      <= base_next;
      init_done_reg <= init_done_next;
      rf_done_reg   <= rf_done_next;
      wr_en_reg     <= wr_en_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
      wr_be_reg     <= wr_be_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and handshake logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    init_cnt_next  = init_cnt_reg;
    beat_cnt_next  = beat_cnt_reg;
    base_next      = base_reg;
    init_done_next = init_done_reg;
    rf_done_next   = 1'b0;
    wr_en_next     = 1'b0;
    wr_addr_next   = wr_addr_reg;
    wr_data_next   = wr_data_reg;
    wr_be_next     = wr_be_reg;
    st_ready       = 1'b0;
    rf_wready      = 1'b0;
    rf_gnt         = 1'b0;

    case (state_reg)
      ST_INIT: begin
        // The extra counter bit sets only after the last address was issued.
        if (init_cnt_reg[ADDR_WIDTH]) begin
          state_next     = ST_IDLE;
          init_done_next = 1'b1;
        end else begin
          wr_en_next    = 1'b1;
          wr_addr_next  = init_cnt_reg[ADDR_WIDTH-1:0];
          wr_data_next  = '0;
          wr_be_next    = '1;
          init_cnt_next = init_cnt_reg + CNT_W'(1);
        end
      end

      ST_IDLE: begin
        if (rf_req) begin
          state_next    = ST_REFILL;
          base_next     = rf_addr & ~LINE_MASK;
          beat_cnt_next = '0;
        end else begin
          st_ready = 1'b1;
          if (st_valid) begin
            wr_en_next   = 1'b1;
            wr_addr_next = st_addr;
            wr_data_next = st_data;
            wr_be_next   = st_be;
          end
        end
      end

      ST_REFILL: begin
        rf_gnt    = 1'b1;
        rf_wready = 1'b1;
        if (rf_wvalid) begin
          wr_en_next   = 1'b1;
          wr_addr_next = base_reg | ADDR_WIDTH'(beat_cnt_reg);
          wr_data_next = rf_wdata;
          wr_be_next   = '1;
          if (beat_cnt_reg == LAST_BEAT) begin
            // rf_done is registered, so it lands with the last beat's write
            // and the cycle in which rf_gnt has already dropped.
            rf_done_next  = 1'b1;
            beat_cnt_next = '0;
            state_next    = ST_IDLE;
          end else begin
            beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
          end
        end
      end

      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read path with write forwarding. The SRAM returns the old word when a
  // read and a write to the same address share a cycle, so the write's
  // enabled bytes are captured and merged into the returned word.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_reg <= 1'b0;
      fwd_hit_reg  <= 1'b0;
      fwd_data_reg <= '0;
      fwd_be_reg   <= '0;
    end else begin
      rd_valid_reg <= rd_req && (state_reg != ST_INIT);
      fwd_hit_reg  <= rd_req && wr_en_reg && (rd_addr == wr_addr_reg);
      fwd_data_reg <= wr_data_reg;
      fwd_be_reg   <= wr_be_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < BE_WIDTH; gi++) begin : g_rd_merge
      assign rd_data[gi*8 +: 8] = (fwd_hit_reg && fwd_be_reg[gi]) ?
                                  fwd_data_reg[gi*8 +: 8] :
                                  sram_rd_data[gi*8 +: 8];
    end
  endgenerate

  assign sram_rd_addr    = rd_addr;
  assign rd_valid        = rd_valid_reg;
  assign init_done       = init_done_reg;
  assign rf_done         = rf_done_reg;
  assign sram_wr_en      = wr_en_reg;
  assign sram_wr_addr    = wr_addr_reg;
  assign sram_wr_data    = wr_data_reg;
  assign sram_wr_byte_en = wr_be_reg;

endmodule

// File: tb/tb_dcache_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dcache_sram_ctrl
//
// Scoreboard bench. The stimulus process keeps a word-level memory image and
// a simple protocol model; every accepted store/beat and every read pushes
// its expected SRAM write or read result (tagged with the cycle it is due)
// into a queue. A monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_dcache_sram_ctrl;

  localparam int AW       = 9;
  localparam int DW       = 32;
  localparam int BW       = 4;
  localparam int LW       = 8;
  localparam int WORDS    = 1 << AW;
  localparam int INIT_CYC = WORDS + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          init_done;
  logic          rf_req;
  logic [AW-1:0] rf_addr;
  logic          rf_gnt;
  logic          rf_wvalid;
  logic [DW-1:0] rf_wdata;
  logic          rf_wready;
  logic          rf_done;
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic [BW-1:0] st_be;
  logic          st_ready;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          sram_wr_en;
  logic [AW-1:0] sram_wr_addr;
  logic [DW-1:0] sram_wr_data;
  logic [BW-1:0] sram_wr_byte_en;
  logic [AW-1:0] sram_rd_addr;
  logic [DW-1:0] sram_rd_data;

  always #5 clk = ~clk;

  dcache_sram_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .LINE_WORDS(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .rf_req(rf_req), .rf_addr(rf_addr), .rf_gnt(rf_gnt),
    .rf_wvalid(rf_wvalid), .rf_wdata(rf_wdata), .rf_wready(rf_wready),
    .rf_done(rf_done),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_be(st_be), .st_ready(st_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr),
    .sram_wr_data(sram_wr_data), .sram_wr_byte_en(sram_wr_byte_en),
    .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data)
  );

  // SRAM model: read returns the pre-write contents one cycle later.
  logic [DW-1:0] sram_mem [0:WORDS-1];
  logic [DW-1:0] sram_q;
  initial begin
    for (int i = 0; i < WORDS; i++) sram_mem[i] = $urandom;
    sram_q = '0;
  end
  always @(posedge clk) begin
    sram_q <= sram_mem[sram_rd_addr];
    if (sram_wr_en)
      for (int b = 0; b < BW; b++)
        if (sram_wr_byte_en[b]) sram_mem[sram_wr_addr][b*8 +: 8] <= sram_wr_data[b*8 +: 8];
  end
  assign sram_rd_data = sram_q;

  // ---------------------------------------------------------------------------
  // Scoreboard and reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
    bit            done;
  } wr_t;
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_t;

  wr_t wr_q[$];
  rd_t rd_q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;

  logic [DW-1:0] ref_mem [0:WORDS-1];
  bit            m_refill;
  int            m_beat;
  logic [AW-1:0] m_base;
  bit            st_acc;
  bit            rf_end;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: evaluate the model on the falling edge with the inputs
  // set for this cycle, then advance past the next rising edge.
  task automatic cycle();
    logic [AW-1:0] a;
    wr_t           w;
    rd_t           r;
    bit            idle;
    @(negedge clk);
    idle = (cyc >= INIT_CYC) && !m_refill;
    check("st_ready", st_ready, idle && !rf_req);
    check("rf_wready", rf_wready, m_refill);
    check("rf_gnt", rf_gnt, m_refill);
    check("init_done", init_done, cyc >= INIT_CYC);
    st_acc = 0;
    rf_end = 0;
    // A read sees every write accepted in earlier cycles, not this one's.
    if (rd_req && cyc >= INIT_CYC) begin
      r.due  = cyc + 1;
      r.data = ref_mem[rd_addr];
      rd_q.push_back(r);
    end
    if (m_refill) begin
      if (rf_wvalid) begin
        a      = m_base | AW'(m_beat);
        w.due  = cyc + 1;
        w.addr = a;
        w.data = rf_wdata;
        w.be   = '1;
        w.done = (m_beat == LW - 1);
        wr_q.push_back(w);
        ref_mem[a] = rf_wdata;
        m_beat++;
        if (m_beat == LW) begin
          m_refill = 0;
          rf_end   = 1;
        end
      end
    end else if (idle) begin
      if (rf_req) begin
        m_refill = 1;
        m_base   = rf_addr & ~(AW'(LW - 1));
        m_beat   = 0;
      end else if (st_valid) begin
        w.due  = cyc + 1;
        w.addr = st_addr;
        w.data = st_data;
        w.be   = st_be;
        w.done = 0;
        wr_q.push_back(w);
        for (int b = 0; b < BW; b++)
          if (st_be[b]) ref_mem[st_addr][b*8 +: 8] = st_data[b*8 +: 8];
        st_acc = 1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    rf_req = 0; rf_addr = '0; rf_wvalid = 0; rf_wdata = '0;
    st_valid = 0; st_addr = '0; st_data = '0; st_be = '0;
    rd_req = 0; rd_addr = '0;
  endtask

  task automatic do_reset(input int hold);
    wr_t w;
    rst_n = 0;
    #1;
    check("rst_wr_en", sram_wr_en, 0);
    check("rst_wr_addr", sram_wr_addr, 0);
    check("rst_wr_data", sram_wr_data, 0);
    check("rst_wr_be", sram_wr_byte_en, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rf_gnt", rf_gnt, 0);
    check("rst_rf_done", rf_done, 0);
    check("rst_init_done", init_done, 0);
    check("rst_st_ready", st_ready, 0);
    check("rst_rf_wready", rf_wready, 0);
    idle_inputs();
    wr_q.delete();
    rd_q.delete();
    m_refill = 0;
    m_beat   = 0;
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1;
    cyc   = 0;
    // The zero-fill sweep: address i is on the write port after edge i+1.
    for (int i = 0; i < WORDS; i++) begin
      ref_mem[i] = '0;
      w.due  = i + 1;
      w.addr = AW'(i);
      w.data = '0;
      w.be   = '1;
      w.done = 0;
      wr_q.push_back(w);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  wr_t mw;
  rd_t mr;
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_q.size() > 0 && wr_q[0].due == cyc) begin
        mw = wr_q.pop_front();
        check("wr_en", sram_wr_en, 1);
        check("wr_addr", sram_wr_addr, mw.addr);
        check("wr_data", sram_wr_data, mw.data);
        check("wr_be", sram_wr_byte_en, mw.be);
        check("rf_done", rf_done, mw.done);
        if (cyc > WORDS)
          $display("wr  cyc=%0d addr=%03h data=%08h be=%h done=%0d",
                   cyc, sram_wr_addr, sram_wr_data, sram_wr_byte_en, rf_done);
      end else begin
        check("wr_unexpected", sram_wr_en, 0);
        check("rf_done_unexpected", rf_done, 0);
      end
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        mr = rd_q.pop_front();
        check("rd_valid", rd_valid, 1);
        check("rd_data", rd_data, mr.data);
        $display("rd  cyc=%0d data=%08h exp=%08h", cyc, rd_data, mr.data);
      end else begin
        check("rd_unexpected", rd_valid, 0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int t;
  int waited;
  bit stopping;

  initial begin
    idle_inputs();
    rst_n = 1;
    #2;
    do_reset(2);

    // Zero-fill with a stray read in the middle of it.
    while (cyc < WORDS) begin
      rd_req  = (cyc == 100);
      rd_addr = 9'h005;
      cycle();
    end
    rd_req = 0;
    check("init_done_at_512", init_done, 0);
    cycle();
    check("init_done_at_513", init_done, 1);

    // Top of the array reads back zero.
    rd_req = 1; rd_addr = 9'h1FF;
    cycle();
    rd_req = 0;
    check("rd_1ff_valid", rd_valid, 1);
    check("rd_1ff_data", rd_data, 32'h0);

    // Store then read two cycles later.
    st_valid = 1; st_addr = 9'h010; st_data = 32'hDEADBEEF; st_be = 4'hF;
    cycle();
    st_valid = 0;
    cycle();
    rd_req = 1; rd_addr = 9'h010;
    cycle();
    rd_req = 0;
    check("store_read_valid", rd_valid, 1);
    check("store_read_data", rd_data, 32'hDEADBEEF);

    // Forwarding of a partial store.
    st_valid = 1; st_addr = 9'h020; st_data = 32'h11223344; st_be = 4'hF;
    cycle();
    st_valid = 0;
    repeat (3) cycle();
    st_valid = 1; st_addr = 9'h020; st_data = 32'hAABBCCDD; st_be = 4'h5;
    cycle();
    st_valid = 0;
    rd_req = 1; rd_addr = 9'h020;
    cycle();
    rd_req = 0;
    check("fwd_valid", rd_valid, 1);
    check("fwd_data", rd_data, 32'h11BB33DD);

    // Refill and store contend; refill wins.
    rf_req = 1; rf_addr = 9'h040;
    st_valid = 1; st_addr = 9'h100; st_data = 32'h5A5A1234; st_be = 4'hF;
    cycle();
    check("gnt_after_req", rf_gnt, 1);
    t = 0;
    while (m_refill && t < 100) begin
      rf_wvalid = ($urandom_range(0, 2) != 0);
      rf_wdata  = DW'(m_beat);
      cycle();
      t++;
    end
    rf_wvalid = 0;
    rf_req    = 0;
    check("refill_complete", m_refill, 0);
    check("rf_done_last", rf_done, 1);
    check("gnt_drops_with_done", rf_gnt, 0);
    waited = 0;
    while (st_valid && waited < 20) begin
      cycle();
      waited++;
      if (st_acc) st_valid = 0;
    end
    check("store_after_refill_wait", waited, 1);
    for (int k = 0; k < LW; k++) begin
      rd_req = 1; rd_addr = AW'(9'h040 + k);
      cycle();
    end
    rd_req = 1; rd_addr = 9'h100;
    cycle();
    rd_req = 0;
    check("store_after_refill_data", rd_data, 32'h5A5A1234);

    // Reset in the middle of a refill after three beats.
    rf_req = 1; rf_addr = 9'h080;
    cycle();
    rf_wvalid = 1;
    repeat (3) begin
      rf_wdata = $urandom;
      cycle();
    end
    do_reset(3);
    while (cyc < INIT_CYC) cycle();
    for (int k = 0; k < 3; k++) begin
      rd_req = 1; rd_addr = AW'(9'h080 + k);
      cycle();
    end
    rd_req = 0;
    check("refilled_word_cleared", rd_data, 32'h0);
    rf_req = 1; rf_addr = 9'h0C5;
    cycle();
    rf_wvalid = 1;
    t = 0;
    while (m_refill && t < 20) begin
      rf_wdata = $urandom;
      cycle();
      t++;
    end
    rf_wvalid = 0;
    rf_req    = 0;
    check("refill2_complete", m_refill, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      stopping = (i >= 2000);
      if (stopping && !m_refill && !rf_req && !st_valid) break;
      if (!m_refill && !rf_req && !stopping && $urandom_range(0, 29) == 0) begin
        rf_req  = 1;
        rf_addr = AW'($urandom_range(0, 127));
      end
      if (m_refill) rf_req = $urandom_range(0, 1);
      rf_wvalid = $urandom_range(0, 1);
      rf_wdata  = $urandom;
      if (!st_valid && !stopping && $urandom_range(0, 2) == 0) begin
        st_valid = 1;
        st_addr  = AW'($urandom_range(0, 127));
        st_data  = $urandom;
        st_be    = BW'($urandom_range(0, 15));
      end
      rd_req  = !stopping && ($urandom_range(0, 1) == 1);
      rd_addr = AW'($urandom_range(0, 127));
      cycle();
      if (rf_end) rf_req = 0;
      if (st_acc) st_valid = 0;
    end
    check("random_drained", {m_refill, rf_req, st_valid}, 0);
    idle_inputs();
    repeat (3) cycle();
    check("wr_queue_empty", wr_q.size(), 0);
    check("rd_queue_empty", rd_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
